// File: rtl/fir_tm_mch.sv
// Multi-channel time-multiplexed FIR: one shared MAC serves NCH delay lines.
// Build option FIR_SAT_EN: saturate Y on overflow (default build wraps).
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes honoured
// MAC   | one tap per cycle into the accumulator
// DONE  | requantise and present Y; may accept the next sample
module fir_tm_mch #(
  parameter int NTAP = 4,
  parameter int NCH  = 2,
  parameter int WI1  = 4,
  parameter int WF1  = 5,
  parameter int WIC  = 4,
  parameter int WFC  = 5,
  parameter int WOI  = 6,
  parameter int WOF  = 5,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int TW  = $clog2(NTAP),
  localparam int WX  = WI1 + WF1,
  localparam int WC  = WIC + WFC,
  localparam int WO  = WOI + WOF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic signed [WX-1:0] X,
  input  logic [CW-1:0]        in_ch,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 coef_we,
  input  logic [TW-1:0]        coef_addr,
  input  logic signed [WC-1:0] coef_data,
  output logic signed [WO-1:0] Y,
  output logic [CW-1:0]        out_ch,
  output logic                 out_valid,
  input  logic                 ovf_clr,
  output logic                 overflow
);

  localparam int WP = WX + WC;
  localparam int G  = $clog2(NTAP);
  localparam int WA = WP + G;
  localparam int SH = WF1 + WFC - WOF;
  localparam int WR = WA - SH;
  localparam int WE = (WR > WO) ? WR : WO;
  localparam logic [TW-1:0] LAST_TAP = TW'(NTAP - 1);
  localparam logic signed [WE-1:0] Y_MAX = {{(WE-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WE-1:0] Y_MIN = {{(WE-WO+1){1'b1}}, {(WO-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_nxt;

  logic signed [WX-1:0] xd [NCH][NTAP];
  logic signed [WC-1:0] coef [NTAP];
  logic signed [WA-1:0] acc;
  logic [TW-1:0]        tap;
  logic [CW-1:0]        ch;
  logic                 drop;

  logic                 accept, ch_ok, coef_wr;
  logic signed [WX-1:0] x_sel;
  logic signed [WC-1:0] c_sel;
  logic signed [WP-1:0] prod;
  logic signed [WR-1:0] r_sig;
  logic signed [WE-1:0] r_ext;
  logic                 ovf_ev;
  logic [WO-1:0]        y_nxt;

  assign in_ready = (state != MAC);
  assign accept   = in_ready && in_valid;
  assign ch_ok    = ({1'b0, in_ch} < (CW+1)'(NCH));
  assign coef_wr  = (state == IDLE) && coef_we && ({1'b0, coef_addr} < (TW+1)'(NTAP));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MAC;
      MAC:     if (tap == LAST_TAP) state_nxt = DONE;
      DONE:    state_nxt = in_valid ? MAC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand mux for the shared multiplier; a dropped channel reads zero.
  always_comb begin
    x_sel = '0;
    c_sel = '0;
    for (int k = 0; k < NTAP; k++) begin
      if (tap == TW'(k)) begin
        c_sel = coef[k];
        for (int c = 0; c < NCH; c++)
          if (ch == CW'(c)) x_sel = xd[c][k];
      end
    end
  end

  assign prod  = WP'(c_sel) * WP'(x_sel);
  assign r_sig = acc[WA-1:SH];
  assign r_ext = WE'(r_sig);
  assign ovf_ev = (r_ext > Y_MAX) || (r_ext < Y_MIN);

`ifdef FIR_SAT_EN
  assign y_nxt = ovf_ev ? (r_ext[WE-1] ? Y_MIN[WO-1:0] : Y_MAX[WO-1:0]) : r_ext[WO-1:0];
`else
  assign y_nxt = r_ext[WO-1:0];
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAP; k++) xd[c][k] <= '0;
      for (int k = 0; k < NTAP; k++) coef[k] <= '0;
      acc       <= '0;
      tap       <= '0;
      ch        <= '0;
      drop      <= 1'b0;
      Y         <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (coef_wr) coef[coef_addr] <= coef_data;

      if (accept) begin
        ch   <= in_ch;
        drop <= !ch_ok;
        tap  <= '0;
        acc  <= '0;
        for (int c = 0; c < NCH; c++) begin
          if (ch_ok && in_ch == CW'(c)) begin
            for (int k = NTAP - 1; k > 0; k--) xd[c][k] <= xd[c][k-1];
            xd[c][0] <= X;
          end
        end
      end else if (state == MAC) begin
        acc <= acc + WA'(prod);
        tap <= tap + TW'(1);
      end

      out_valid <= 1'b0;
      if (state == DONE && !drop) begin
        Y         <= y_nxt;
        out_ch    <= ch;
        out_valid <= 1'b1;
      end

      // A fresh overflow event wins over a simultaneous clear.
      if (state == DONE && !drop && ovf_ev) overflow <= 1'b1;
      else if (ovf_clr)                     overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tm_mch.sv
// Self-checking bench for fir_tm_mch: directed cases plus randomised traffic
// scored against a sum-of-products reference model.
module tb_fir_tm_mch;
  localparam int NTAP = 4, NCH = 2, WI1 = 4, WF1 = 5, WIC = 4, WFC = 5, WOI = 6, WOF = 5;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(NTAP);
  localparam int WX = WI1 + WF1, WC = WIC + WFC, WO = WOI + WOF;
  localparam int SH = WF1 + WFC - WOF;
  localparam longint OMAX = (longint'(1) << (WO - 1)) - 1;
  localparam longint OMIN = -(longint'(1) << (WO - 1));

  logic                 CLK = 0, RESET = 1;
  logic signed [WX-1:0] X = '0;
  logic [CW-1:0]        in_ch = '0;
  logic                 in_valid = 0, in_ready;
  logic                 coef_we = 0;
  logic [TW-1:0]        coef_addr = '0;
  logic signed [WC-1:0] coef_data = '0;
  logic signed [WO-1:0] Y;
  logic [CW-1:0]        out_ch;
  logic                 out_valid, ovf_clr = 0, overflow;

  fir_tm_mch #(.NTAP(NTAP), .NCH(NCH), .WI1(WI1), .WF1(WF1), .WIC(WIC), .WFC(WFC),
               .WOI(WOI), .WOF(WOF)) dut (
    .CLK(CLK), .RESET(RESET), .X(X), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(in_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .Y(Y), .out_ch(out_ch), .out_valid(out_valid),
    .ovf_clr(ovf_clr), .overflow(overflow));

  always #5 CLK = ~CLK;

  typedef struct {int ch; longint y; bit ovf; int due;} exp_t;
  exp_t   exp_q[$];
  exp_t   e;
  longint hist [NCH][NTAP];
  longint coefm [NTAP];
  bit     ovfm;
  int     cyc = 0, mac_lo = 1, mac_hi = 0, last_acc = 0;
  longint last_y;
  int     n_tests = 0, n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference: explicit per-channel history, full sum, floor, then wrap/clamp.
  task automatic model_push(input int ch, input longint x, input int due);
    longint s, q, w;
    bit ev;
    exp_t n;
    for (int k = NTAP - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = x;
    s = 0;
    for (int k = 0; k < NTAP; k++) s += coefm[k] * hist[ch][k];
    q  = s >>> SH;
    ev = (q > OMAX) || (q < OMIN);
    w  = q & ((longint'(1) << WO) - 1);
    if (w > OMAX) w -= (longint'(1) << WO);
`ifdef FIR_SAT_EN
    if (ev) w = (q > OMAX) ? OMAX : OMIN;
`endif
    ovfm = ovfm | ev;
    n.ch = ch; n.y = w; n.ovf = ovfm; n.due = due;
    exp_q.push_back(n);
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      chk("in_ready", in_ready, (cyc >= mac_lo && cyc <= mac_hi) ? 0 : 1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("y", Y, e.y);
          chk("out_ch", out_ch, e.ch);
          chk("overflow", overflow, e.ovf);
          chk("latency", cyc, e.due);
          last_y = Y;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RESET = 1; in_valid = 0; coef_we = 0; ovf_clr = 0;
    exp_q.delete(); mac_lo = 1; mac_hi = 0; ovfm = 0;
    for (int c = 0; c < NCH; c++) for (int k = 0; k < NTAP; k++) hist[c][k] = 0;
    for (int k = 0; k < NTAP; k++) coefm[k] = 0;
    #1;
    chk("rst_y", Y, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge CLK);
    #2 RESET = 0;
  endtask

  task automatic write_coef(input int addr, input longint data);
    @(negedge CLK);
    coef_we = 1; coef_addr = TW'(addr); coef_data = WC'(data);
    coefm[addr] = data;
    @(negedge CLK);
    coef_we = 0;
  endtask

  task automatic feed(input int ch, input longint x, input bit we = 0,
                      input int waddr = 0, input longint wdata = 0);
    int n = 0;
    @(negedge CLK);
    X = WX'(x); in_ch = CW'(ch); in_valid = 1;
    while (!in_ready && n < 20) begin @(negedge CLK); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    if (we) begin
      coef_we = 1; coef_addr = TW'(waddr); coef_data = WC'(wdata);
      coefm[waddr] = wdata;
    end
    mac_lo = cyc + 1; mac_hi = cyc + NTAP;
    last_acc = cyc + 1;
    model_push(ch, x, cyc + NTAP + 2);
    @(posedge CLK);
    #1 coef_we = 0;
  endtask

  task automatic idle();
    @(negedge CLK);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge CLK); n++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge CLK);
  endtask

  task automatic clear_ovf();
    @(negedge CLK); ovf_clr = 1;
    @(negedge CLK); ovf_clr = 0;
    ovfm = 0;
    chk("ovf_cleared", overflow, 0);
  endtask

  initial begin
    int prev, nb;
    longint imp [4] = '{16, 8, -8, 32};
    longint stim [4] = '{32, 0, 0, 0};

    do_reset();
    for (int k = 0; k < NTAP; k++) write_coef(k, imp[k]);

    // Impulse on ch0, back-to-back, with no idle gap between accepts
    for (int i = 0; i < 4; i++) begin
      prev = last_acc;
      feed(0, stim[i]);
      if (i > 0) chk("b2b_gap", last_acc - prev, NTAP + 1);
    end
    idle(); drain();
    chk("impulse_last_y", last_y, 32);

    // Channel isolation: ch0 impulse interleaved with ch1 = 64,0,0,0
    for (int i = 0; i < 4; i++) begin
      feed(0, stim[i]);
      feed(1, 2 * stim[i]);
    end
    idle(); drain();
    chk("iso_ch1_last_y", last_y, 64);

    // Randomised traffic with occasional coefficient updates and flag clears
    for (int b = 0; b < 30; b++) begin
      if ($urandom_range(0, 3) == 0)
        write_coef($urandom_range(0, NTAP - 1), longint'($urandom_range(0, 511)) - 256);
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        if (i == 0 && $urandom_range(0, 3) == 0)
          feed($urandom_range(0, NCH - 1), longint'($urandom_range(0, 511)) - 256,
               1, $urandom_range(0, NTAP - 1), longint'($urandom_range(0, 511)) - 256);
        else
          feed($urandom_range(0, NCH - 1), longint'($urandom_range(0, 511)) - 256);
      end
      idle(); drain();
      if ($urandom_range(0, 2) == 0) clear_ovf();
    end

    // Coefficient write during MAC is ignored
    do_reset();
    for (int k = 0; k < NTAP; k++) write_coef(k, imp[k]);
    feed(0, 32);
    @(negedge CLK);
    in_valid = 0; coef_we = 1; coef_addr = '0; coef_data = '0;
    @(negedge CLK);
    coef_we = 0;
    drain();
    chk("guard_y", last_y, 16);

    // Overflow: all coefficients and samples at full scale
    for (int k = 0; k < NTAP; k++) write_coef(k, 255);
    for (int i = 0; i < 4; i++) feed(0, 255);
    idle(); drain();
`ifdef FIR_SAT_EN
    chk("ovf_y", last_y, 1023);
`else
    chk("ovf_y", last_y, -64);
`endif
    chk("ovf_flag", overflow, 1);
    clear_ovf();

    // Clear coinciding with a new overflow event leaves the flag set
    feed(0, 255);
    idle();
    while (cyc < last_acc + NTAP) @(negedge CLK);
    ovf_clr = 1;
    @(negedge CLK);
    ovf_clr = 0;
    drain();
    chk("ovf_clr_collision", overflow, 1);

    // Reset mid-MAC discards the sample and zeroes coefficients
    feed(0, 100);
    idle();
    @(negedge CLK);
    do_reset();
    repeat (8) @(negedge CLK);
    last_y = 999;
    for (int i = 0; i < 4; i++) feed(0, stim[i]);
    idle(); drain();
    chk("post_rst_y", last_y, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
